// File: rtl/tva_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tva_pkg
//  Description : Shared types, lane indices and the precision-code to lane
//                mapping used by the token precision scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package tva_pkg;

   // Precision codes produced by the token precision analyzer
   typedef enum logic [3:0] {
      PREC_INT4 = 4'd0,
      PREC_INT8 = 4'd1,
      PREC_FP16 = 4'd2
   } prec_code_e;

   // Compute lane indices (bit positions in lane_valid/lane_ready/lane_done)
   localparam logic [1:0] LANE_INT4 = 2'd0;
   localparam logic [1:0] LANE_INT8 = 2'd1;
   localparam logic [1:0] LANE_FP16 = 2'd2;

   // Scheduler control states
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_DRAIN    = 2'd2,
      S_DONE     = 2'd3
   } sched_state_e;

   // Unknown codes (3..15) run at full precision on the FP16 lane
   function automatic logic [1:0] prec_to_lane(input logic [3:0] code);
      case (code)
         PREC_INT4: return LANE_INT4;
         PREC_INT8: return LANE_INT8;
         default:   return LANE_FP16;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_credit_counter
//  Description : Tracks outstanding tokens for one compute lane. Issues count
//                up, completions count down; a completion on an empty lane is
//                flagged and otherwise ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_credit_counter #(
   parameter int MAX_OUT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic issue,
   input  logic retire,
   output logic has_credit,
   output logic credit_next,
   output logic empty,
   output logic underflow_err
);

   localparam int               OUT_W = $clog2(MAX_OUT + 1);
   localparam logic [OUT_W-1:0] LIMIT = OUT_W'(MAX_OUT);

   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] outstanding_nxt;
   logic             retire_ok;

   // Next outstanding count; simultaneous issue and retire cancel out
   always_comb begin
      retire_ok       = retire & (outstanding != '0);
      outstanding_nxt = outstanding;
      if (issue && !retire_ok) begin
         outstanding_nxt = outstanding + OUT_W'(1);
      end else if (!issue && retire_ok) begin
         outstanding_nxt = outstanding - OUT_W'(1);
      end
   end

   // Outstanding-token register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_nxt;
      end
   end

   assign has_credit    = (outstanding < LIMIT);
   // Lets the scheduler register a request that is legal after this edge
   assign credit_next   = (outstanding_nxt < LIMIT);
   assign empty         = (outstanding == '0);
   assign underflow_err = retire & empty;

endmodule
`default_nettype wire

// File: rtl/token_precision_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : token_precision_scheduler
//  Description : Issues L key tokens in index order to the INT4/INT8/FP16
//                compute lanes over per-lane valid/ready, respecting a per-lane
//                outstanding-work credit limit, and pulses done once all
//                tokens are issued and every lane has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_precision_scheduler
   import tva_pkg::*;
#(
   parameter  int L       = 8,
   parameter  int MAX_OUT = 2,
   localparam int IDX_W   = (L > 1) ? $clog2(L) : 1,
   localparam int CNT_W   = $clog2(L + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*L-1:0]       prec_in,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           lane_valid,
   output logic [IDX_W-1:0]     lane_idx,
   input  logic [2:0]           lane_ready,
   input  logic [2:0]           lane_done,
   output logic [3*CNT_W-1:0]   lane_cnt,
   output logic                 err
);

   sched_state_e     state;
   logic [3:0]       prec [L];
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] next_ptr;
   logic [2:0]       valid_q;
   logic [2:0]       issue;
   logic [2:0]       has_credit;
   logic [2:0]       credit_next;
   logic [2:0]       empty;
   logic [2:0]       underflow;
   logic [CNT_W-1:0] cnt [3];
   logic             last;
   logic [3:0]       head_code;
   logic [1:0]       head_lane;
   logic [2:0]       head_onehot;
   logic             head_go;

   // One credit counter per lane; also packs the per-lane issue counts
   for (genvar k = 0; k < 3; k++) begin : g_lane
      lane_credit_counter #(
         .MAX_OUT (MAX_OUT)
      ) u_credit (
         .clk           (clk),
         .rst_n         (rst_n),
         .issue         (issue[k]),
         .retire        (lane_done[k]),
         .has_credit    (has_credit[k]),
         .credit_next   (credit_next[k]),
         .empty         (empty[k]),
         .underflow_err (underflow[k])
      );
      assign lane_cnt[k*CNT_W +: CNT_W] = cnt[k];
   end

   // valid_q is only ever set with credit available, so this gate is a no-op safeguard
   assign lane_valid = valid_q & has_credit;
   assign issue      = lane_valid & lane_ready;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign last       = (ptr == IDX_W'(L - 1));

   // Head-of-line token for the next cycle and whether its lane will have credit
   always_comb begin
      next_ptr = ptr;
      if ((issue != 3'b000) && !last) begin
         next_ptr = ptr + IDX_W'(1);
      end
      head_code   = (state == S_IDLE) ? prec_in[3:0] : prec[next_ptr];
      head_lane   = prec_to_lane(head_code);
      head_onehot = 3'b001 << head_lane;
      head_go     = credit_next[head_lane];
   end

   // Scheduler FSM with registered request, index, counters and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= '0;
         lane_idx <= '0;
         valid_q  <= '0;
         err      <= 1'b0;
         for (int i = 0; i < L; i++) prec[i] <= '0;
         for (int k = 0; k < 3; k++) cnt[k] <= '0;
      end else begin
         if ((state == S_IDLE) && start) begin
            err <= |underflow;
         end else if (|underflow) begin
            err <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < L; i++) prec[i] <= prec_in[4*i +: 4];
                  for (int k = 0; k < 3; k++) cnt[k] <= '0;
                  ptr      <= '0;
                  lane_idx <= '0;
                  valid_q  <= head_go ? head_onehot : 3'b000;
                  state    <= S_DISPATCH;
               end
            end
            S_DISPATCH: begin
               for (int k = 0; k < 3; k++) cnt[k] <= cnt[k] + CNT_W'(issue[k]);
               if ((issue != 3'b000) && last) begin
                  valid_q <= 3'b000;
                  state   <= S_DRAIN;
               end else if ((issue != 3'b000) || (valid_q == 3'b000)) begin
                  // Advance after an accept, or raise a stalled request once credit returns
                  ptr      <= next_ptr;
                  lane_idx <= next_ptr;
                  valid_q  <= head_go ? head_onehot : 3'b000;
               end
            end
            S_DRAIN: begin
               if (&empty) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_token_precision_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_token_precision_scheduler
//  Description : Directed and randomized bench for token_precision_scheduler
//                with a transaction-level reference model of issue order,
//                lane credits, error flag and batch phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_token_precision_scheduler;

   localparam int L       = 8;
   localparam int MAX_OUT = 2;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 4;

   // Reference-model batch phases
   localparam int P_IDLE  = 0;
   localparam int P_DISP  = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic               clk        = 1'b0;
   logic               rst_n      = 1'b0;
   logic               start      = 1'b0;
   logic [4*L-1:0]     prec_in    = '0;
   logic [2:0]         lane_ready = '0;
   logic [2:0]         lane_done  = '0;
   logic               busy;
   logic               done;
   logic               err;
   logic [2:0]         lane_valid;
   logic [IDX_W-1:0]   lane_idx;
   logic [3*CNT_W-1:0] lane_cnt;

   int         checks = 0;
   int         errors = 0;
   int         codes [L];
   int         m_phase;
   int         m_next;
   int         m_out [3];
   int         m_cnt [3];
   logic       m_err;
   int         m_lane [L];
   logic [2:0] m_last_issue;
   int         lat;

   always #5 clk = ~clk;

   token_precision_scheduler #(
      .L       (L),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .prec_in    (prec_in),
      .busy       (busy),
      .done       (done),
      .lane_valid (lane_valid),
      .lane_idx   (lane_idx),
      .lane_ready (lane_ready),
      .lane_done  (lane_done),
      .lane_cnt   (lane_cnt),
      .err        (err)
   );

   function automatic int lane_of(input int code);
      if (code == 0) return 0;
      if (code == 1) return 1;
      return 2;
   endfunction

   // Request the model expects this cycle: head token's lane, if it has credit
   function automatic logic [2:0] exp_valid();
      logic [2:0] v;
      v = 3'b000;
      if (m_phase == P_DISP && m_next < L && m_out[m_lane[m_next]] < MAX_OUT)
         v[m_lane[m_next]] = 1'b1;
      return v;
   endfunction

   function automatic logic [2:0] pending_mask();
      logic [2:0] v;
      for (int k = 0; k < 3; k++) v[k] = (m_out[k] > 0);
      return v;
   endfunction

   function automatic logic [2:0] rand_done();
      logic [2:0] v;
      for (int k = 0; k < 3; k++)
         v[k] = (m_out[k] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 15) == 0);
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_next  = 0;
      m_err   = 1'b0;
      m_last_issue = 3'b000;
      for (int k = 0; k < 3; k++) begin
         m_out[k] = 0;
         m_cnt[k] = 0;
      end
   endtask

   task automatic load_codes();
      for (int i = 0; i < L; i++) prec_in[4*i +: 4] = 4'(codes[i]);
   endtask

   task automatic compare_outputs();
      logic [2:0]         ev;
      logic [3*CNT_W-1:0] ec;
      ev = exp_valid();
      for (int k = 0; k < 3; k++) ec[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
      check("busy", {31'd0, busy}, {31'd0, (m_phase != P_IDLE)});
      check("done", {31'd0, done}, {31'd0, (m_phase == P_DONE)});
      check("lane_valid", {29'd0, lane_valid}, {29'd0, ev});
      if (ev != 3'b000) check("lane_idx", {29'd0, lane_idx}, m_next);
      check("lane_cnt", {20'd0, lane_cnt}, {20'd0, ec});
      check("err", {31'd0, err}, {31'd0, m_err});
   endtask

   // Advance the model across one rising edge given the inputs driven for it
   task automatic model_step(input logic st, input logic [2:0] rdy, input logic [2:0] dn);
      logic [2:0] iss;
      logic       uf;
      logic       drained;
      iss     = exp_valid() & rdy;
      uf      = 1'b0;
      drained = (m_out[0] == 0) && (m_out[1] == 0) && (m_out[2] == 0);
      for (int k = 0; k < 3; k++) begin
         if (dn[k] && m_out[k] == 0) uf = 1'b1;
         m_out[k] = m_out[k] + (iss[k] ? 1 : 0) - ((dn[k] && m_out[k] > 0) ? 1 : 0);
      end
      m_last_issue = iss;
      m_err = (m_phase == P_IDLE && st) ? uf : (m_err | uf);
      case (m_phase)
         P_IDLE: begin
            if (st) begin
               m_phase = P_DISP;
               m_next  = 0;
               for (int k = 0; k < 3; k++) m_cnt[k] = 0;
               for (int i = 0; i < L; i++) m_lane[i] = lane_of(int'(prec_in[4*i +: 4]));
            end
         end
         P_DISP: begin
            for (int k = 0; k < 3; k++) begin
               if (iss[k]) begin
                  m_cnt[k]++;
                  m_next++;
               end
            end
            if (m_next == L) m_phase = P_DRAIN;
         end
         P_DRAIN: if (drained) m_phase = P_DONE;
         default: m_phase = P_IDLE;
      endcase
   endtask

   // One cycle: check outputs, drive inputs, update model, move to next negedge
   task automatic tick(input logic st, input logic [2:0] rdy, input logic [2:0] dn);
      compare_outputs();
      start      = st;
      lane_ready = rdy;
      lane_done  = dn;
      model_step(st, rdy, dn);
      @(negedge clk);
   endtask

   task automatic finish_batch(input logic rnd, input string tag);
      for (int c = 0; c < 200; c++) begin
         if (m_phase == P_IDLE) break;
         if (rnd) tick(1'b0, 3'($urandom), rand_done());
         else     tick(1'b0, 3'b111, pending_mask());
      end
      check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;

      // Mixed codes, immediate completions: order, counts, latency
      codes = '{0, 1, 2, 0, 1, 2, 0, 1};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         if (done) begin
            lat = c;
            break;
         end
         tick(1'b0, 3'b111, m_last_issue);
      end
      check("t1_latency", lat, L + 3);
      finish_batch(1'b0, "t1");
      check("t1_cnt", {20'd0, lane_cnt}, 32'h233);
      check("t1_err", {31'd0, err}, 32'd0);

      // Credit stall on INT4 lane and resume after one completion
      codes = '{0, 0, 0, 0, 0, 0, 0, 0};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      for (int c = 0; c < 9; c++) tick(1'b0, 3'b111, 3'b000);
      check("t2_stall_valid", {29'd0, lane_valid}, 32'd0);
      check("t2_stall_cnt", {20'd0, lane_cnt}, 32'h002);
      tick(1'b0, 3'b111, 3'b001);
      check("t2_resume_valid", {29'd0, lane_valid}, 32'd1);
      check("t2_resume_idx", {29'd0, lane_idx}, 32'd2);
      tick(1'b0, 3'b111, 3'b000);
      check("t2_resume_cnt", {20'd0, lane_cnt}, 32'h003);
      finish_batch(1'b0, "t2");

      // Codes above 2 all go to FP16
      codes = '{5, 15, 3, 2, 9, 12, 4, 7};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      finish_batch(1'b1, "t3");
      check("t3_cnt", {20'd0, lane_cnt}, 32'h800);

      // Back-pressure on INT8 while idx 3 is requested
      codes = '{0, 2, 0, 1, 0, 0, 0, 0};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      for (int c = 0; c < 20; c++) begin
         if (m_phase == P_DISP && m_next == 3 && exp_valid() == 3'b010) break;
         tick(1'b0, 3'b111, m_last_issue);
      end
      for (int c = 0; c < 4; c++) begin
         check("t4_hold_valid", {29'd0, lane_valid}, 32'd2);
         check("t4_hold_idx", {29'd0, lane_idx}, 32'd3);
         tick(1'b0, 3'b101, m_last_issue);
      end
      check("t4_hold_cnt", {20'd0, lane_cnt}, 32'h102);
      finish_batch(1'b0, "t4");

      // Issue and completion on the same lane, plus a stray FP16 completion
      codes = '{0, 0, 0, 0, 0, 0, 0, 0};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      tick(1'b0, 3'b111, 3'b000);
      tick(1'b0, 3'b111, 3'b101);
      check("t5_err", {31'd0, err}, 32'd1);
      check("t5_valid", {29'd0, lane_valid}, 32'd1);
      tick(1'b0, 3'b111, 3'b000);
      check("t5_stall", {29'd0, lane_valid}, 32'd0);
      check("t5_cnt", {20'd0, lane_cnt}, 32'h003);
      finish_batch(1'b0, "t5");

      // Asynchronous reset in mid-dispatch, late completion, then a clean batch
      codes = '{0, 1, 2, 0, 1, 2, 0, 1};
      load_codes();
      tick(1'b1, 3'b111, 3'b000);
      for (int c = 0; c < 20; c++) begin
         if (m_next == 4) break;
         tick(1'b0, 3'b111, m_last_issue);
      end
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_done", {31'd0, done}, 32'd0);
      check("t6_rst_valid", {29'd0, lane_valid}, 32'd0);
      check("t6_rst_cnt", {20'd0, lane_cnt}, 32'd0);
      check("t6_rst_err", {31'd0, err}, 32'd0);
      model_reset();
      lane_done = 3'b000;
      @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;
      tick(1'b0, 3'b000, 3'b010);
      check("t6_late_err", {31'd0, err}, 32'd1);
      tick(1'b1, 3'b111, 3'b000);
      finish_batch(1'b0, "t6");
      check("t6_cnt", {20'd0, lane_cnt}, 32'h233);

      // Randomized batches: random codes, ready and completions
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < L; i++) codes[i] = int'($urandom_range(0, 15));
         load_codes();
         tick(1'b1, 3'($urandom), rand_done());
         finish_batch(1'b1, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/token_precision_scheduler.md
Name: token_precision_scheduler

Overview:
Dispatches the L key tokens to three precision-specific compute lanes (INT4, INT8, FP16) using the per-token 4-bit precision codes from the token precision analyzer. Tokens are issued strictly in index order over a valid/ready handshake per lane. Each lane has a credit limit on outstanding work. The block signals done once every token has been issued and every lane has returned its completions. It sits between the analyzer and the mixed-precision matmul lanes.

Parameters:
L, 8, number of key tokens per batch (must be >= 1)
MAX_OUT, 2, maximum outstanding tokens per lane (must be >= 1)
IDX_W, $clog2(L) (minimum 1), width of a token index
CNT_W, $clog2(L+1), width of the per-lane issue counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a batch; sampled only in S_IDLE
prec_in  in  4*L  precision codes; token i occupies bits [4*i+3:4*i]; code 0=INT4, 1=INT8, 2=FP16, 3..15 treated as FP16
busy  out  1  high in every state except S_IDLE
done  out  1  one-cycle pulse when the batch is complete
lane_valid  out  3  per-lane issue request; bit0=INT4, bit1=INT8, bit2=FP16
lane_idx  out  IDX_W  index of the token being issued; shared by all lanes
lane_ready  in  3  per-lane accept
lane_done  in  3  per-lane completion pulse; one pulse per finished token
lane_cnt  out  3*CNT_W  number of tokens issued per lane this batch; lane k occupies bits [k*CNT_W +: CNT_W]
err  out  1  sticky; set when lane_done arrives while that lane has 0 outstanding; cleared only by reset or by start

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, state S_IDLE, pointer 0, credits 0, counters 0.
- States:
  - S_IDLE: when start=1, latch prec_in into an internal array, clear ptr/lane_cnt/err, go to S_DISPATCH. start is ignored in every other state.
  - S_DISPATCH: decode code c = prec[ptr] into lane k. lane_valid[k] = 1 only when outstanding[k] < MAX_OUT; all other lane_valid bits are 0. lane_idx = ptr.
    - Handshake: lane_valid[k] & lane_ready[k] => issue. outstanding[k]++, lane_cnt[k]++, ptr++.
    - Once valid is asserted, it and lane_idx stay stable until accepted. A valid is never withdrawn.
    - Issue of token L-1 moves to S_DRAIN.
    - lane_valid is registered: first request appears the cycle after start is sampled. Sustained throughput is 1 token per cycle when ready is held high and credits are available.
  - S_DRAIN: lane_valid = 0. Wait until all outstanding counters are 0, then go to S_DONE.
  - S_DONE: done = 1 for exactly one cycle. Go to S_IDLE (busy = 0 next cycle).
- Credit rules (apply in every state, including S_IDLE for late pulses):
  - lane_done[k] decrements outstanding[k].
  - lane_done[k] and an issue to lane k in the same cycle leave outstanding[k] unchanged.
  - lane_done[k] with outstanding[k] = 0 sets err. The counter stays at 0 (no underflow).
- Credit stall: when outstanding[k] = MAX_OUT, lane_valid[k] stays low until a lane_done[k] arrives. Valid may rise in the cycle after that done.
- In-order head-of-line blocking is intentional: a stalled lane stalls every later token.
- Arithmetic: outstanding counters are $clog2(MAX_OUT+1) bits. lane_cnt saturates impossibly (max L). ptr never wraps within a batch.
- Reset mid-batch: everything returns to reset values immediately. No done pulse. Completions arriving after reset with 0 outstanding set err.
- Minimum batch latency with immediate completions: L+3 cycles from start to done.

Decomposition:
- Shared package (tva_pkg):
  - enum prec_code_e {PREC_INT4=0, PREC_INT8=1, PREC_FP16=2}.
  - Lane index constants LANE_INT4/LANE_INT8/LANE_FP16.
  - Function prec_to_lane(logic [3:0]) mapping codes >2 to LANE_FP16.
  - State enum sched_state_e {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE}.
- One sub-module: lane_credit_counter, instantiated three times.
  - Inputs: issue, retire.
  - Outputs: has_credit, empty, underflow_err.
  - Parameter: MAX_OUT.

Test Plan:
1. L=8, codes {0,1,2,0,1,2,0,1}, all ready=1, lane_done pulsed the cycle after each issue -> issue order idx 0..7 on lanes 0,1,2,0,1,2,0,1; lane_cnt = {3,3,2}; done 11 cycles after start; err=0.
2. All codes 0, MAX_OUT=2, no lane_done until cycle 10 -> idx 0,1 issued, then lane_valid[0] held low; after one lane_done[0], idx 2 issues the following cycle.
3. Codes {5,15,3,2,...} -> all routed to FP16 lane; lane_cnt = {0,0,8}.
4. lane_ready[1] held low 4 cycles while idx 3 is requested -> lane_valid[1] and lane_idx=3 stable for all 4 cycles; no later token issues.
5. Simultaneous lane_done[0] and issue to lane 0 at outstanding=1 -> outstanding stays 1; extra lane_done[2] at outstanding 0 -> err=1, counter stays 0.
6. rst_n low during S_DISPATCH at ptr=4 -> all outputs 0 asynchronously; no done; a new start after release runs a full batch correctly.
